// File: rtl/scoreboard_controller.sv
// Score/display sequencer for a two-player scoreboard: holds both scores, detects the
// winner and schedules the shared display (alternate, hold-on-change, winner lock).
module scoreboard_controller #(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned DISP_PERIOD = 1000,
  parameter int unsigned HOLD_CYCLES = 2000
) (
  input  logic       clk_1khz,
  input  logic       rst,
  input  logic       up_a_i,
  input  logic       down_a_i,
  input  logic       up_b_i,
  input  logic       down_b_i,
  output logic [6:0] score_a_o,
  output logic [6:0] score_b_o,
  output logic       disp_sel_o,
  output logic [6:0] disp_value_o,
  output logic       game_over_o,
  output logic       winner_o
);

  localparam int unsigned PerW  = (DISP_PERIOD > 1) ? $clog2(DISP_PERIOD) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PerW-1:0]  PerMax   = PerW'(DISP_PERIOD - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYCLES - 1);
  localparam logic [6:0]       WinScore = 7'(WIN_SCORE);

  typedef enum logic [1:0] {StAlternate, StHoldA, StHoldB, StGameOver} state_e;

  state_e state_q, state_d;

  logic [6:0]       score_a_q, score_a_d;
  logic [6:0]       score_b_q, score_b_d;
  logic             disp_sel_q, disp_sel_d;
  logic             winner_q, winner_d;
  logic [PerW-1:0]  per_cnt_q, per_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  logic playing;
  logic inc_a, dec_a, win_a, chg_a;
  logic inc_b_raw, win_b_raw;
  logic inc_b, dec_b, win_b, chg_b;
  logic restart;
  logic per_done, hold_done, in_hold;

  // Event decode: up+down together cancels, down at zero is dropped.
  always_comb begin
    playing   = (state_q != StGameOver);
    inc_a     = playing & up_a_i & ~down_a_i;
    dec_a     = playing & down_a_i & ~up_a_i & (score_a_q != 7'd0);
    win_a     = inc_a & ((score_a_q + 7'd1) == WinScore);
    inc_b_raw = playing & up_b_i & ~down_b_i;
    win_b_raw = inc_b_raw & ((score_b_q + 7'd1) == WinScore);
    // A simultaneous double win goes to A; B's winning point is discarded.
    inc_b     = inc_b_raw & ~(win_a & win_b_raw);
    win_b     = win_b_raw & ~win_a;
    dec_b     = playing & down_b_i & ~up_b_i & (score_b_q != 7'd0);
    chg_a     = inc_a | dec_a;
    chg_b     = inc_b | dec_b;
    restart   = ~playing & down_a_i & down_b_i;
    per_done  = (per_cnt_q == PerMax);
    hold_done = (hold_cnt_q == HoldMax);
    in_hold   = (state_q == StHoldA) || (state_q == StHoldB);
  end

  // State register
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q <= StAlternate;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StAlternate, StHoldA, StHoldB: begin
        if (win_a || win_b) begin
          state_d = StGameOver;
        end else if (chg_a) begin
          state_d = StHoldA;
        end else if (chg_b) begin
          state_d = StHoldB;
        end else if (in_hold && hold_done) begin
          state_d = StAlternate;
        end
      end
      StGameOver: begin
        if (restart) begin
          state_d = StAlternate;
        end
      end
      default: state_d = StAlternate;
    endcase
  end

  // Datapath next-state: scores, winner, display owner and timers
  always_comb begin
    score_a_d  = score_a_q;
    score_b_d  = score_b_q;
    winner_d   = winner_q;
    disp_sel_d = disp_sel_q;
    per_cnt_d  = '0;
    hold_cnt_d = '0;

    if (restart) begin
      score_a_d  = 7'd0;
      score_b_d  = 7'd0;
      winner_d   = 1'b0;
      disp_sel_d = 1'b0;
    end else begin
      if (inc_a) begin
        score_a_d = score_a_q + 7'd1;
      end else if (dec_a) begin
        score_a_d = score_a_q - 7'd1;
      end
      if (inc_b) begin
        score_b_d = score_b_q + 7'd1;
      end else if (dec_b) begin
        score_b_d = score_b_q - 7'd1;
      end

      if (win_a) begin
        winner_d = 1'b0;
      end else if (win_b) begin
        winner_d = 1'b1;
      end

      // Winner locks the display; otherwise the latest change owns it.
      if (win_a) begin
        disp_sel_d = 1'b0;
      end else if (win_b) begin
        disp_sel_d = 1'b1;
      end else if (chg_a) begin
        disp_sel_d = 1'b0;
      end else if (chg_b) begin
        disp_sel_d = 1'b1;
      end else if ((state_q == StAlternate) && per_done) begin
        disp_sel_d = ~disp_sel_q;
      end
    end

    if ((state_q == StAlternate) && (state_d == StAlternate) && !per_done) begin
      per_cnt_d = per_cnt_q + PerW'(1);
    end

    if (in_hold && (state_d == state_q) && !chg_a && !chg_b) begin
      hold_cnt_d = hold_cnt_q + HoldW'(1);
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      score_a_q  <= 7'd0;
      score_b_q  <= 7'd0;
      winner_q   <= 1'b0;
      disp_sel_q <= 1'b0;
      per_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      score_a_q  <= score_a_d;
      score_b_q  <= score_b_d;
      winner_q   <= winner_d;
      disp_sel_q <= disp_sel_d;
      per_cnt_q  <= per_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Outputs
  always_comb begin
    score_a_o    = score_a_q;
    score_b_o    = score_b_q;
    disp_sel_o   = disp_sel_q;
    disp_value_o = disp_sel_q ? score_b_q : score_a_q;
    game_over_o  = (state_q == StGameOver);
    winner_o     = winner_q;
  end

endmodule

// File: tb/tb_scoreboard_controller.sv
// Scoreboard bench for scoreboard_controller: a time-based reference model predicts
// each cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_scoreboard_controller;

  localparam int unsigned WinScore   = 11;
  localparam int unsigned DispPeriod = 1000;
  localparam int unsigned HoldCycles = 2000;

  logic       clk_1khz = 1'b0;
  logic       rst      = 1'b1;
  logic       up_a_i   = 1'b0;
  logic       down_a_i = 1'b0;
  logic       up_b_i   = 1'b0;
  logic       down_b_i = 1'b0;
  logic [6:0] score_a_o, score_b_o, disp_value_o;
  logic       disp_sel_o, game_over_o, winner_o;

  scoreboard_controller #(
    .WIN_SCORE  (WinScore),
    .DISP_PERIOD(DispPeriod),
    .HOLD_CYCLES(HoldCycles)
  ) dut (
    .clk_1khz    (clk_1khz),
    .rst         (rst),
    .up_a_i      (up_a_i),
    .down_a_i    (down_a_i),
    .up_b_i      (up_b_i),
    .down_b_i    (down_b_i),
    .score_a_o   (score_a_o),
    .score_b_o   (score_b_o),
    .disp_sel_o  (disp_sel_o),
    .disp_value_o(disp_value_o),
    .game_over_o (game_over_o),
    .winner_o    (winner_o)
  );

  initial forever #5 clk_1khz = ~clk_1khz;

  typedef struct {
    int         cyc;
    logic [6:0] sa;
    logic [6:0] sb;
    logic [6:0] val;
    logic       sel;
    logic       over;
    logic       win;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: display owner is derived from elapsed time since the
  // alternation began or since the last accepted change.
  int m_n = 0;
  int m_sa, m_sb, m_hold_start, m_alt_start;
  bit m_over, m_win, m_hold, m_hold_sel, m_alt_base;

  task automatic model_clear();
    m_sa = 0; m_sb = 0; m_over = 0; m_win = 0;
    m_hold = 0; m_alt_start = m_n; m_alt_base = 0;
  endtask

  task automatic model_step(input bit ua, input bit da, input bit ub, input bit db,
                            input bit r);
    int delta_a, delta_b;
    m_n++;
    if (r) begin
      model_clear();
      return;
    end
    if (m_over) begin
      if (da && db) model_clear();
      return;
    end
    delta_a = (ua && !da) ? 1 : ((da && !ua && m_sa > 0) ? -1 : 0);
    delta_b = (ub && !db) ? 1 : ((db && !ub && m_sb > 0) ? -1 : 0);
    if (delta_a == 1 && m_sa + 1 == int'(WinScore) && delta_b == 1 &&
        m_sb + 1 == int'(WinScore)) delta_b = 0;
    m_sa += delta_a;
    m_sb += delta_b;
    if (m_sa == int'(WinScore)) begin
      m_over = 1; m_win = 0;
    end else if (m_sb == int'(WinScore)) begin
      m_over = 1; m_win = 1;
    end
    if (m_over) return;
    if (delta_a != 0) begin
      m_hold = 1; m_hold_sel = 0; m_hold_start = m_n;
    end else if (delta_b != 0) begin
      m_hold = 1; m_hold_sel = 1; m_hold_start = m_n;
    end else if (m_hold && (m_n - m_hold_start) >= int'(HoldCycles)) begin
      m_hold = 0; m_alt_start = m_n; m_alt_base = m_hold_sel;
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    bit   sel;
    if (m_over) sel = m_win;
    else if (m_hold) sel = m_hold_sel;
    else sel = m_alt_base ^ bit'(((m_n - m_alt_start) / int'(DispPeriod)) % 2);
    e.cyc  = m_n;
    e.sa   = 7'(m_sa);
    e.sb   = 7'(m_sb);
    e.sel  = sel;
    e.val  = sel ? 7'(m_sb) : 7'(m_sa);
    e.over = m_over;
    e.win  = m_win;
    return e;
  endfunction

  task automatic tick(input bit ua, input bit da, input bit ub, input bit db, input bit r);
    up_a_i = ua; down_a_i = da; up_b_i = ub; down_b_i = db; rst = r;
    model_step(ua, da, ub, db, r);
    exp_q.push_back(model_expect());
    @(posedge clk_1khz);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected record per clock edge, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_1khz);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (score_a_o !== e.sa || score_b_o !== e.sb || disp_sel_o !== e.sel ||
            disp_value_o !== e.val || game_over_o !== e.over ||
            (e.over && winner_o !== e.win)) begin
          errors++;
          $display("FAIL outputs cyc=%0d got a=%0d b=%0d sel=%0b val=%0d over=%0b win=%0b exp a=%0d b=%0d sel=%0b val=%0d over=%0b win=%0b",
                   e.cyc, score_a_o, score_b_o, disp_sel_o, disp_value_o, game_over_o,
                   winner_o, e.sa, e.sb, e.sel, e.val, e.over, e.win);
        end
      end
    end
  end

  initial begin
    bit ua, da, ub, db, rr;
    model_clear();

    // Reset then free-running alternation
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    idle(2500);

    // Single change, hold, then alternation resumes
    tick(1, 0, 0, 0, 0);
    idle(2100);
    idle(1200);

    // Ignored events
    tick(0, 0, 0, 1, 0);
    idle(5);
    tick(1, 1, 0, 0, 0);
    idle(5);

    // A climbs to the win, game-over behaviour, restart
    repeat (9) begin
      tick(1, 0, 0, 0, 0);
      idle(3);
    end
    tick(1, 0, 0, 0, 0);
    idle(3);
    tick(0, 0, 1, 0, 0);
    tick(0, 1, 0, 0, 0);
    idle(3);
    tick(0, 1, 0, 1, 0);
    idle(3);

    // Simultaneous wins go to A
    repeat (10) begin
      tick(1, 0, 1, 0, 0);
      idle(1);
    end
    tick(1, 0, 1, 0, 0);
    idle(3);
    tick(0, 1, 0, 1, 0);
    idle(3);

    // Reset mid HOLD_B and in GAME_OVER
    tick(0, 0, 1, 0, 0);
    idle(50);
    tick(0, 0, 0, 0, 1);
    idle(10);
    repeat (11) tick(0, 0, 1, 0, 0);
    idle(5);
    tick(0, 0, 0, 0, 1);
    idle(1200);

    // Random segments alternating quiet and busy traffic
    for (int s = 0; s < 10; s++) begin
      int len, pm;
      len = int'($urandom_range(300, 3500));
      pm  = (s % 2 == 1) ? 25 : 2;
      for (int i = 0; i < len; i++) begin
        ua = int'($urandom_range(0, 999)) < pm;
        da = int'($urandom_range(0, 999)) < pm;
        ub = int'($urandom_range(0, 999)) < pm;
        db = int'($urandom_range(0, 999)) < pm;
        if (m_over && $urandom_range(0, 99) == 0) begin
          da = 1; db = 1;
        end
        rr = ($urandom_range(0, 4999) == 0);
        tick(ua, da, ub, db, rr);
      end
    end

    idle(2);
    @(negedge clk_1khz);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending records, need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
